// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Accepts two register-file operands and produces MUL/MULH/MULHSU/MULHU/
// DIV/DIVU/REM/REMU results on a one-cycle register-file write strobe.
// Ports:
//   clk, rst (async active-low)
//   start, kill, funct3, rs1_data, rs2_data, rd_addr   request side
//   ready, busy                                       core handshake/stall
//   wb_we, wb_rd, wb_wd                               register-file write port
// Configuration macro: MULDIV_FAST_MUL_EN selects a single-cycle
// combinational multiplier; when undefined all multiplies iterate.
module muldiv_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  kill,
  input  logic [2:0]            funct3,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  ready,
  output logic                  busy,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_wd
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned PW    = 2 * XLEN;
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [2:0]            r_funct3, w_funct3_nxt;
  logic [REG_ADDR_W-1:0] r_rd, w_rd_nxt;
  logic                  r_neg, w_neg_nxt;
  logic [XLEN-1:0]       r_hi, w_hi_nxt;
  logic [XLEN-1:0]       r_lo, w_lo_nxt;
  logic [XLEN-1:0]       r_b, w_b_nxt;
  logic [XLEN-1:0]       r_result, w_result_nxt;

  // Operand decode at accept time
  logic            w_in_div;
  logic            w_a_signed, w_b_signed;
  logic            w_sa, w_sb;
  logic            w_in_neg;
  logic [XLEN-1:0] w_mag_a, w_mag_b;
  logic            w_b_zero;
  logic            w_div_ovf;

  always_comb begin
    w_in_div   = funct3[2];
    // Multiplies: A signed unless MULHU, B signed only for MUL/MULH.
    // Divides: both signed for DIV/REM (funct3[0]==0).
    w_a_signed = w_in_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    w_b_signed = w_in_div ? ~funct3[0] : ~funct3[1];
    w_sa       = w_a_signed & rs1_data[XLEN-1];
    w_sb       = w_b_signed & rs2_data[XLEN-1];
    w_mag_a    = w_sa ? -rs1_data : rs1_data;
    w_mag_b    = w_sb ? -rs2_data : rs2_data;
    // Remainder takes the dividend sign; everything else takes sA^sB
    w_in_neg   = (w_in_div && funct3[1]) ? w_sa : (w_sa ^ w_sb);
    w_b_zero   = (rs2_data == '0);
    w_div_ovf  = w_in_div && !funct3[0] && (rs1_data == INT_MIN) && (rs2_data == ALL_ONES);
  end

`ifdef MULDIV_FAST_MUL_EN
  // Single-cycle multiplier on magnitudes, sign applied afterwards
  logic [PW-1:0]   w_fast_prod, w_fast_prod_s;
  logic [XLEN-1:0] w_fast_result;

  always_comb begin
    w_fast_prod   = PW'(w_mag_a) * PW'(w_mag_b);
    w_fast_prod_s = w_in_neg ? -w_fast_prod : w_fast_prod;
    if (funct3[1:0] == 2'b00) w_fast_result = w_fast_prod_s[XLEN-1:0];
    else                      w_fast_result = w_fast_prod_s[PW-1:XLEN];
  end
`endif

  // One shift-add / restoring-divide step on the working registers.
  // Multiply: {r_hi,r_lo} is the product, r_lo starts as the multiplier.
  // Divide: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN:0]   w_diff;
  logic            w_q_bit;
  logic [XLEN-1:0] w_step_hi, w_step_lo;

  always_comb begin
    w_mul_sum = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : '0)};
    w_rem_sh  = {r_hi, r_lo[XLEN-1]};
    w_diff    = w_rem_sh - {1'b0, r_b};
    w_q_bit   = ~w_diff[XLEN];
    if (r_funct3[2]) begin
      w_step_hi = w_q_bit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
      w_step_lo = {r_lo[XLEN-2:0], w_q_bit};
    end else begin
      w_step_hi = w_mul_sum[XLEN:1];
      w_step_lo = {w_mul_sum[0], r_lo[XLEN-1:1]};
    end
  end

  // Result formatting after the last step: sign fix-up and half select
  logic [PW-1:0]   w_prod, w_prod_s;
  logic [XLEN-1:0] w_div_sel, w_div_s;
  logic [XLEN-1:0] w_final;

  always_comb begin
    w_prod    = {w_step_hi, w_step_lo};
    w_prod_s  = r_neg ? -w_prod : w_prod;
    w_div_sel = r_funct3[1] ? w_step_hi : w_step_lo;
    w_div_s   = r_neg ? -w_div_sel : w_div_sel;
    if (r_funct3[2])                w_final = w_div_s;
    else if (r_funct3[1:0] == 2'b00) w_final = w_prod_s[XLEN-1:0];
    else                            w_final = w_prod_s[PW-1:XLEN];
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_rd     <= '0;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_funct3 <= w_funct3_nxt;
      r_rd     <= w_rd_nxt;
      r_neg    <= w_neg_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_b      <= w_b_nxt;
      r_result <= w_result_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_funct3_nxt = r_funct3;
    w_rd_nxt     = r_rd;
    w_neg_nxt    = r_neg;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_b_nxt      = r_b;
    w_result_nxt = r_result;

    case (r_state)
      S_IDLE: begin
        if (start && !kill) begin
          w_funct3_nxt = funct3;
          w_rd_nxt     = rd_addr;
          w_neg_nxt    = w_in_neg;
          if (w_in_div && w_b_zero) begin
            w_result_nxt = funct3[1] ? rs1_data : ALL_ONES;
            w_state_nxt  = S_DONE;
          end else if (w_div_ovf) begin
            w_result_nxt = funct3[1] ? '0 : INT_MIN;
            w_state_nxt  = S_DONE;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!w_in_div) begin
            w_result_nxt = w_fast_result;
            w_state_nxt  = S_DONE;
          end
`endif
          else begin
            w_hi_nxt    = '0;
            w_lo_nxt    = w_in_div ? w_mag_a : w_mag_b;
            w_b_nxt     = w_in_div ? w_mag_b : w_mag_a;
            w_cnt_nxt   = CNT_W'(XLEN - 1);
            w_state_nxt = S_CALC;
          end
        end
      end
      S_CALC: begin
        w_hi_nxt  = w_step_hi;
        w_lo_nxt  = w_step_lo;
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == '0) begin
          w_result_nxt = w_final;
          w_state_nxt  = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort wins over everything, including a same-cycle start
    if (kill) w_state_nxt = S_IDLE;
  end

  // Handshake and write port; kill gates the strobe in the same cycle
  always_comb begin
    ready = (r_state == S_IDLE);
    busy  = (r_state != S_IDLE);
    wb_we = (r_state == S_DONE) && !kill && (r_rd != '0);
    wb_rd = r_rd;
    wb_wd = r_result;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_addr;
  logic        ready;
  logic        busy;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wd;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_BUSY = 1;
`else
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_BUSY = 33;

  muldiv_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .kill     (kill),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_addr  (rd_addr),
    .ready    (ready),
    .busy     (busy),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_wd    (wb_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, and watch the busy window.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int exp_busy,
                        input logic [31:0] exp_wd);
    int          c;
    int          nwe;
    int          we_at;
    logic [31:0] wd;
    logic [4:0]  wrd;
    chk({tag, " ready_before"}, 32'(ready), 32'd1);
    funct3   = f3;
    rs1_data = a;
    rs2_data = b;
    rd_addr  = rd;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    rs1_data = $urandom;
    rs2_data = $urandom;
    rd_addr  = 5'($urandom);
    c = 0; nwe = 0; we_at = 0; wd = '0; wrd = '0;
    while (busy === 1'b1 && c < 100) begin
      c++;
      if (wb_we === 1'b1) begin
        nwe++;
        we_at = c;
        wd    = wb_wd;
        wrd   = wb_rd;
      end
      tick();
    end
    chk({tag, " busy_cycles"}, 32'(c), 32'(exp_busy));
    chk({tag, " we_count"}, 32'(nwe), (rd != 5'd0) ? 32'd1 : 32'd0);
    if (rd != 5'd0) begin
      chk({tag, " we_cycle"}, 32'(we_at), 32'(exp_busy));
      chk({tag, " wb_rd"}, 32'(wrd), 32'(rd));
      chk({tag, " wb_wd"}, wd, exp_wd);
    end
    chk({tag, " ready_after"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int nwe;
    int first_at;
    int last_at;
    int gap;
    logic [31:0] wd;

    rst = 1'b0; start = 1'b0; kill = 1'b0; funct3 = '0;
    rs1_data = '0; rs2_data = '0; rd_addr = '0;
    tick();
    tick();
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset wb_we", 32'(wb_we), 32'd0);
    chk("reset wb_rd", 32'(wb_rd), 32'd0);
    chk("reset wb_wd", wb_wd, 32'd0);
    rst = 1'b1;
    tick();

    // Multiplies
    run_op("MUL 7*-3",        F_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  MUL_BUSY, 32'hFFFFFFEB);
    run_op("MULHU -1*-1",     F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  MUL_BUSY, 32'hFFFFFFFE);
    run_op("MULH -1*-1",      F_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  MUL_BUSY, 32'h00000000);
    run_op("MULHSU -1*2",     F_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd8,  MUL_BUSY, 32'hFFFFFFFF);
    run_op("MULHU 2^16*2^16", F_MULHU,  32'h00010000, 32'h00010000, 5'd9,  MUL_BUSY, 32'h00000001);
    run_op("MUL 2^16*2^16",   F_MUL,    32'h00010000, 32'h00010000, 5'd10, MUL_BUSY, 32'h00000000);

    // Divides
    run_op("DIV -20/6",       F_DIV,  32'hFFFFFFEC, 32'd6,        5'd11, DIV_BUSY, 32'hFFFFFFFD);
    run_op("REM -20%6",       F_REM,  32'hFFFFFFEC, 32'd6,        5'd12, DIV_BUSY, 32'hFFFFFFFE);
    run_op("DIVU 100/7",      F_DIVU, 32'd100,      32'd7,        5'd13, DIV_BUSY, 32'd14);
    run_op("REMU 100%7",      F_REMU, 32'd100,      32'd7,        5'd14, DIV_BUSY, 32'd2);
    run_op("DIV 7/-2",        F_DIV,  32'd7,        32'hFFFFFFFE, 5'd15, DIV_BUSY, 32'hFFFFFFFD);
    run_op("REM 7%-2",        F_REM,  32'd7,        32'hFFFFFFFE, 5'd16, DIV_BUSY, 32'd1);
    run_op("REMU big%16",     F_REMU, 32'hFFFFFFFF, 32'd16,       5'd17, DIV_BUSY, 32'd15);

    // Special cases bypass the iteration
    run_op("DIVU by zero",    F_DIVU, 32'h00001234, 32'd0,        5'd18, 1, 32'hFFFFFFFF);
    run_op("REM by zero",     F_REM,  32'h00001234, 32'd0,        5'd19, 1, 32'h00001234);
    run_op("DIV overflow",    F_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd20, 1, 32'h80000000);
    run_op("REM overflow",    F_REM,  32'h80000000, 32'hFFFFFFFF, 5'd21, 1, 32'h00000000);

    // x0 destination: op runs, no write strobe
    run_op("MUL rd0",         F_MUL,  32'd7,        32'hFFFFFFFD, 5'd0,  MUL_BUSY, 32'h0);

    // Kill 10 cycles into a divide
    funct3 = F_DIV; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr = 5'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("kill busy_before", 32'(busy), 32'd1);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill ready_next", 32'(ready), 32'd1);
    nwe = 0;
    for (int i = 0; i < 40; i++) begin
      if (wb_we === 1'b1) nwe++;
      tick();
    end
    chk("kill no_writeback", 32'(nwe), 32'd0);

    // Kill during DONE gates the strobe in the same cycle
    funct3 = F_DIVU; rs1_data = 32'h1234; rs2_data = 32'd0; rd_addr = 5'd4; start = 1'b1;
    tick();
    start = 1'b0;
    chk("done busy", 32'(busy), 32'd1);
    kill = 1'b1;
    #1;
    chk("kill_in_done wb_we", 32'(wb_we), 32'd0);
    tick();
    kill = 1'b0;
    chk("kill_in_done ready", 32'(ready), 32'd1);

    // start and kill together in IDLE: not accepted
    funct3 = F_DIVU; rs1_data = 32'h55; rs2_data = 32'd0; rd_addr = 5'd22;
    start = 1'b1; kill = 1'b1;
    tick();
    start = 1'b0; kill = 1'b0;
    chk("start_kill ready", 32'(ready), 32'd1);
    chk("start_kill busy", 32'(busy), 32'd0);
    chk("start_kill wb_we", 32'(wb_we), 32'd0);

    // Async reset mid-CALC
    funct3 = F_DIVU; rs1_data = 32'd100; rs2_data = 32'd7; rd_addr = 5'd23; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("midcalc busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_rst ready", 32'(ready), 32'd1);
    chk("async_rst busy", 32'(busy), 32'd0);
    chk("async_rst wb_we", 32'(wb_we), 32'd0);
    chk("async_rst wb_rd", 32'(wb_rd), 32'd0);
    chk("async_rst wb_wd", wb_wd, 32'd0);
    rst = 1'b1;
    tick();

    // start held high: one accept every 34 cycles, each result written once
    funct3 = F_DIVU; rs1_data = 32'd100; rs2_data = 32'd7; rd_addr = 5'd3; start = 1'b1;
    nwe = 0; first_at = -1; last_at = -1; gap = 0; wd = '0;
    for (int i = 0; i < 110; i++) begin
      if (wb_we === 1'b1) begin
        nwe++;
        if (first_at < 0) first_at = i;
        else if (gap == 0) gap = i - last_at;
        last_at = i;
        wd = wb_wd;
      end
      tick();
    end
    start = 1'b0;
    chk("b2b we_count", 32'(nwe), 32'd3);
    chk("b2b first_we", 32'(first_at), 32'd33);
    chk("b2b spacing", 32'(gap), 32'd34);
    chk("b2b wb_wd", wd, 32'd14);
    for (int i = 0; i < 100 && busy === 1'b1; i++) tick();
    chk("b2b drain ready", 32'(ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
